// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction store and PC sequencer feeding the core over valid/ready
module instr_fetch_unit #(
  parameter int unsigned DATA_W    = 9,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned RESET_PC  = 0,
  parameter int unsigned HALT_WORD = 256
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              run,
  input  logic              restart,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fault
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_RST  = ADDR_W'(RESET_PC);
  localparam logic [DATA_W-1:0] HALT_W  = DATA_W'(HALT_WORD);

  typedef enum logic [1:0] {IDLE, FETCH, VALID, HALT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic pc_in_range;
  logic load_in_range;

  assign pc_in_range   = ({1'b0, pc_q} < DEPTH_X);
  assign load_in_range = ({1'b0, load_addr} < DEPTH_X);

  // Memory is not reset so a program survives Resetn; reads below see pre-edge contents.
  always_ff @(posedge clk) begin
    if (Resetn && load_en && load_in_range) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        if (pc_in_range) begin
          instr_d = mem_q[pc_q];
          valid_d = 1'b1;
          state_d = VALID;
        end else begin
          fault_d  = 1'b1;
          halted_d = 1'b1;
          state_d  = HALT;
        end
      end
      VALID: begin
        if (instr_ready) begin
          valid_d = 1'b0;
          pc_d    = jmp ? jmp_addr : pc_q + 1'b1;
          if (instr_q == HALT_W) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            state_d = run ? FETCH : IDLE;
          end
        end
      end
      HALT: begin
        if (restart) begin
          pc_d     = PC_RST;
          halted_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      pc_q     <= PC_RST;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Parametrised instruction memory plus program-counter sequencer that feeds the cute processor core one instruction word at a time over a valid/ready handshake.
- Adds three things to the current fixed nine-word store:
  - a run-time program load port;
  - jump-target redirect on instruction accept;
  - a halt-word stop and an out-of-range fault stop.
- Sits between the program loader/testbench and the core's DIN input; the core's done output drives instr_ready.

Parameters:
- DATA_W, 9: instruction word width.
- ADDR_W, 6: PC and memory address width.
- DEPTH, 64: number of memory words. Must satisfy 1 <= DEPTH <= 2^ADDR_W.
- RESET_PC, 0: PC value after reset and after restart.
- HALT_WORD, 256 (9'b100000000): a fetched word equal to this value stops sequencing.

Ports:
- clk  in  1  clock, rising edge.
- Resetn  in  1  synchronous reset, active-low.
- run  in  1  level; enables fetching.
- restart  in  1  pulse; leaves HALT.
- load_en  in  1  memory write strobe.
- load_addr  in  ADDR_W  write address.
- load_data  in  DATA_W  write data.
- instr  out  DATA_W  fetched instruction (registered).
- instr_valid  out  1  instr holds a valid word.
- instr_ready  in  1  core accepts instr (connect to core done).
- jmp  in  1  redirect PC on accept (connect to core jmp).
- jmp_addr  in  ADDR_W  redirect target.
- pc  out  ADDR_W  address of the current or next fetch.
- halted  out  1  in HALT state.
- fault  out  1  sticky; a fetch was attempted at pc >= DEPTH.

Behaviour:
- Reset:
  - Resetn is sampled on the rising clk edge; when 0: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, halted=0, fault=0.
  - Memory contents are preserved. load_en is ignored while Resetn=0.
  - Reset mid-handshake drops instr_valid on the next edge; a pending accept is discarded.
- States: IDLE, FETCH, VALID, HALT. All transitions occur on the clk edge.
- IDLE:
  - run=1 -> FETCH.
  - Otherwise stay.
- FETCH:
  - If pc < DEPTH: instr<=mem[pc], instr_valid<=1 -> VALID.
  - If pc >= DEPTH: fault<=1, halted<=1, instr_valid stays 0 -> HALT.
- VALID:
  - instr and instr_valid are held stable while instr_ready=0, regardless of run.
  - On an edge with instr_ready=1: instr_valid<=0.
  - Next pc: if jmp=1, pc<=jmp_addr; else pc<=pc+1 (mod 2^ADDR_W).
  - jmp and jmp_addr are sampled only on the accept edge.
  - If instr==HALT_WORD: halted<=1 -> HALT. The pc update still happens.
  - Else if run=1 -> FETCH; else -> IDLE.
- HALT:
  - Outputs hold; halted=1.
  - restart=1 -> pc<=RESET_PC, halted<=0 -> IDLE. fault stays set until Resetn.
  - run and instr_ready are ignored.
- Latency:
  - run rising in IDLE -> instr_valid=1 after the 2nd edge.
  - Accept edge -> next instr_valid=1 after 2 further edges (one FETCH cycle in between).
  - Peak throughput: 1 instruction per 2 cycles.
- Wrap:
  - pc=DEPTH-1 accepted without jmp: pc becomes DEPTH.
  - If DEPTH < 2^ADDR_W, the next FETCH faults.
  - If DEPTH == 2^ADDR_W, pc wraps to 0 and sequencing continues.
- jmp_addr >= DEPTH is accepted into pc; the fault is raised at the following FETCH.
- Load port:
  - Writes occur in any state when Resetn=1; writes with load_addr >= DEPTH are ignored.
  - A write and a FETCH read to the same address on the same edge return the old data (read-before-write).
  - A write to the address whose word is already latched in instr does not change instr.
- Simultaneous events:
  - Resetn=0 overrides all other inputs.
  - Outside HALT, restart is ignored.

Test Plan:
- Load mem[0..3]={9'h041,9'h013,9'h0C3,HALT_WORD}, run=1, instr_ready tied 1 -> instr sequence 041,013,0C3,100 with instr_valid pulses 2 cycles apart; halted=1 after the 4th accept; pc=4.
- Backpressure: hold instr_ready=0 for 5 cycles at pc=1 -> instr=013 and instr_valid=1 stable for all 5 cycles; pc stays 1; asserting ready -> pc=2.
- Jump: accept at pc=2 with jmp=1, jmp_addr=0 -> next instr=mem[0], pc=0; jmp=1 asserted while instr_ready=0 has no effect.
- Fault: DEPTH=10, ADDR_W=6, jmp_addr=12 accepted -> next FETCH sets fault=1 and halted=1, instr_valid stays 0; restart -> pc=0, halted=0, fault still 1; Resetn=0 clears fault.
- Wrap: DEPTH=64, ADDR_W=6, pc=63, word is not HALT_WORD, accept -> pc=0 and fetch continues with no fault.
- Reset and load collisions: Resetn=0 while instr_valid=1 -> instr_valid=0 and pc=RESET_PC next edge, memory retained; load_en to the address being fetched on the same edge -> instr shows the old word and the following fetch of that address shows the new one.
